// File: rtl/hps_fifo_sched.sv
// rtl/hps_fifo_sched.sv - HPS<->FPGA Avalon FIFO read sequencer and round-robin write arbiter
// Optional rd/wr word counters are built when HPS_FIFO_SCHED_STATS_EN is defined.
module hps_fifo_sched #(
  parameter int DATA_W      = 32,
  parameter int F2H_DEPTH   = 256,
  parameter int FILL_MARGIN = 4,
  parameter int RD_LAT      = 1,
  parameter int CSR_LAT     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h2f_empty,
  output logic              h2f_rd,
  input  logic              h2f_waitrequest,
  input  logic [DATA_W-1:0] h2f_rdata,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic              wr_req0,
  input  logic              wr_req1,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  output logic              wr_gnt0,
  output logic              wr_gnt1,
  input  logic [31:0]       f2h_fill,
  output logic              f2h_wr,
  output logic [DATA_W-1:0] f2h_wdata,
  input  logic              f2h_waitrequest,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  typedef enum logic [1:0] {IDLE, RD, LAT, HOLD} rd_state_t;

  localparam logic [32:0] WR_LIMIT = 33'(F2H_DEPTH - FILL_MARGIN);

  rd_state_t state, state_nxt;
  logic [2:0] lat_cnt;
  logic [2:0] holdoff;
  logic       rd_accept;
  logic       lat_done;
  logic       rx_hs;

  assign h2f_rd    = (state == RD);
  assign rd_accept = (state == RD) && !h2f_waitrequest;
  assign lat_done  = (state == LAT) && (lat_cnt == 3'(RD_LAT - 1));
  assign rx_hs     = rx_valid && rx_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!h2f_empty && holdoff == 3'd0 && !rx_valid) state_nxt = RD;
      RD:   if (!h2f_waitrequest) state_nxt = LAT;
      LAT:  if (lat_done) state_nxt = HOLD;
      HOLD: if (rx_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // holdoff masks the empty flag until the CSR readback reflects the last pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lat_cnt  <= 3'd0;
      holdoff  <= 3'd0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= (state == LAT) ? lat_cnt + 3'd1 : 3'd0;
      if (rd_accept)
        holdoff <= 3'(CSR_LAT);
      else if (holdoff != 3'd0)
        holdoff <= holdoff - 3'd1;
      if (lat_done) begin
        rx_data  <= h2f_rdata;
        rx_valid <= 1'b1;
      end else if (rx_hs) begin
        rx_valid <= 1'b0;
      end
    end
  end

  logic [CSR_LAT-1:0] infl_sr;
  logic [3:0]         inflight;
  logic [32:0]        fill_sum;
  logic               permitted;
  logic               wr_accept;
  logic               wr_start;
  logic               sel;
  logic               wsel;
  logic               favour;

  always_comb begin
    inflight = 4'd0;
    for (int i = 0; i < CSR_LAT; i++)
      inflight = inflight + {3'd0, infl_sr[i]};
  end

  // writes still invisible in the stale fill readback are added back in
  assign fill_sum  = {1'b0, f2h_fill} + {29'd0, inflight};
  assign permitted = fill_sum < WR_LIMIT;
  assign wr_accept = f2h_wr && !f2h_waitrequest;
  assign wr_start  = !f2h_wr && permitted && (wr_req0 || wr_req1);
  assign sel       = (wr_req0 && wr_req1) ? favour : wr_req1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f2h_wr    <= 1'b0;
      f2h_wdata <= '0;
      wsel      <= 1'b0;
      favour    <= 1'b0;
      wr_gnt0   <= 1'b0;
      wr_gnt1   <= 1'b0;
      infl_sr   <= '0;
    end else begin
      wr_gnt0 <= wr_accept && !wsel;
      wr_gnt1 <= wr_accept && wsel;
      infl_sr <= (infl_sr << 1) | CSR_LAT'(wr_accept);
      if (wr_accept) begin
        f2h_wr <= 1'b0;
        favour <= ~wsel;
      end else if (wr_start) begin
        f2h_wr    <= 1'b1;
        wsel      <= sel;
        f2h_wdata <= sel ? wr_data1 : wr_data0;
      end
    end
  end

`ifdef HPS_FIFO_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else begin
      if (rx_hs)     rd_count <= rd_count + 16'd1;
      if (wr_accept) wr_count <= wr_count + 16'd1;
    end
  end
`else
  assign rd_count = 16'd0;
  assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_hps_fifo_sched.sv
// tb/tb_hps_fifo_sched.sv - directed self-checking bench for hps_fifo_sched
// Counter expectations follow HPS_FIFO_SCHED_STATS_EN.
module tb_hps_fifo_sched;

`ifdef HPS_FIFO_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        h2f_empty, h2f_rd, h2f_waitrequest;
  logic [31:0] h2f_rdata, rx_data;
  logic        rx_valid, rx_ready;
  logic        wr_req0, wr_req1, wr_gnt0, wr_gnt1;
  logic [31:0] wr_data0, wr_data1, f2h_fill, f2h_wdata;
  logic        f2h_wr, f2h_waitrequest;
  logic [15:0] rd_count, wr_count;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_wr     = 0;
  bit          fill_track = 1'b0;
  logic [1:0]  fill_pipe = 2'b00;

  always #10 clk = ~clk;

  hps_fifo_sched dut (
    .clk(clk), .rst(rst),
    .h2f_empty(h2f_empty), .h2f_rd(h2f_rd), .h2f_waitrequest(h2f_waitrequest),
    .h2f_rdata(h2f_rdata), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .wr_req0(wr_req0), .wr_req1(wr_req1), .wr_data0(wr_data0), .wr_data1(wr_data1),
    .wr_gnt0(wr_gnt0), .wr_gnt1(wr_gnt1), .f2h_fill(f2h_fill), .f2h_wr(f2h_wr),
    .f2h_wdata(f2h_wdata), .f2h_waitrequest(f2h_waitrequest),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the fill readback lags accepted writes by two cycles when tracking
  task automatic tick();
    logic acc;
    acc = f2h_wr && !f2h_waitrequest;
    @(posedge clk);
    #1;
    if (acc) n_wr++;
    if (fill_track) begin
      if (fill_pipe[1]) f2h_fill = f2h_fill + 32'd1;
      fill_pipe = {fill_pipe[0], acc};
    end
  endtask

  initial begin
    rst = 1'b0;
    h2f_empty = 1'b1; h2f_waitrequest = 1'b0; h2f_rdata = 32'h0; rx_ready = 1'b0;
    wr_req0 = 1'b0; wr_req1 = 1'b0; wr_data0 = 32'h0; wr_data1 = 32'h0;
    f2h_fill = 32'd0; f2h_waitrequest = 1'b0;
    repeat (3) tick();
    chk("rst_h2f_rd", h2f_rd, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_f2h_wr", f2h_wr, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_wr_count", wr_count, 0);
    rst = 1'b1;
    tick();

    // single read
    h2f_rdata = 32'h5; rx_ready = 1'b1; h2f_empty = 1'b0;
    tick();
    chk("t1_rd_pulse", h2f_rd, 1);
    h2f_empty = 1'b1;
    tick();
    chk("t1_rd_drop", h2f_rd, 0);
    chk("t1_not_valid_yet", rx_valid, 0);
    tick();
    chk("t1_rx_valid", rx_valid, 1);
    chk("t1_rx_data", rx_data, 32'h5);
    tick();
    chk("t1_rx_taken", rx_valid, 0);
    chk("t1_rd_count", rd_count, STATS ? 1 : 0);
    repeat (4) begin
      tick();
      chk("t1_no_second_rd", h2f_rd, 0);
    end

    // read backpressure and consumer stall
    h2f_waitrequest = 1'b1; rx_ready = 1'b0; h2f_rdata = 32'h1234; h2f_empty = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t2_rd_held", h2f_rd, 1);
      if (i == 3) h2f_waitrequest = 1'b0;
      tick();
    end
    chk("t2_rd_released", h2f_rd, 0);
    tick();
    h2f_rdata = 32'hDEAD;
    for (int i = 0; i < 10; i++) begin
      chk("t2_valid_hold", rx_valid, 1);
      chk("t2_data_stable", rx_data, 32'h1234);
      chk("t2_no_rd_while_full", h2f_rd, 0);
      tick();
    end
    rx_ready = 1'b1;
    tick();
    chk("t2_taken", rx_valid, 0);
    chk("t2_idle_no_rd", h2f_rd, 0);
    tick();
    chk("t2_second_rd", h2f_rd, 1);
    h2f_empty = 1'b1;
    tick();
    tick();
    chk("t2_second_data", rx_data, 32'hDEAD);
    chk("t2_second_valid", rx_valid, 1);
    tick();
    chk("t2_rd_count", rd_count, STATS ? 3 : 0);

    // round-robin between two held requesters
    wr_req0 = 1'b1; wr_data0 = 32'hA0; wr_req1 = 1'b1; wr_data1 = 32'hB1;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t3_wr", f2h_wr, 1);
      chk("t3_wdata", f2h_wdata, (k % 2 == 0) ? 32'hA0 : 32'hB1);
      tick();
      chk("t3_gap", f2h_wr, 0);
      chk("t3_gnt0", wr_gnt0, (k % 2 == 0) ? 1 : 0);
      chk("t3_gnt1", wr_gnt1, (k % 2 == 0) ? 0 : 1);
      if (k == 3) begin wr_req0 = 1'b0; wr_req1 = 1'b0; end
      tick();
    end
    chk("t3_idle", f2h_wr, 0);

    // fill guard with lagging fill readback
    n_wr = 0; f2h_fill = 32'd250; fill_pipe = 2'b00; fill_track = 1'b1;
    wr_req0 = 1'b1; wr_data0 = 32'h55;
    repeat (12) tick();
    chk("t4_writes", n_wr, 2);
    chk("t4_blocked", f2h_wr, 0);
    chk("t4_fill_model", f2h_fill, 32'd252);
    fill_track = 1'b0; f2h_fill = 32'd252;
    repeat (8) tick();
    chk("t4_still_2", n_wr, 2);
    f2h_fill = 32'hFFFF_FFFF;
    repeat (6) tick();
    chk("t4_no_wrap", n_wr, 2);
    chk("t4_no_wrap_wr", f2h_wr, 0);
    wr_req0 = 1'b0; f2h_fill = 32'd0;
    tick();

    // write held by waitrequest
    f2h_waitrequest = 1'b1; wr_req0 = 1'b1; wr_data0 = 32'h77;
    tick();
    wr_data0 = 32'h99;
    for (int i = 0; i < 6; i++) begin
      chk("t5_wr_held", f2h_wr, 1);
      chk("t5_wdata_held", f2h_wdata, 32'h77);
      chk("t5_no_gnt", wr_gnt0, 0);
      if (i == 5) f2h_waitrequest = 1'b0;
      tick();
    end
    chk("t5_gnt0", wr_gnt0, 1);
    chk("t5_gnt1", wr_gnt1, 0);
    chk("t5_wr_done", f2h_wr, 0);
    wr_req0 = 1'b0;
    tick();
    chk("t5_gnt_pulse", wr_gnt0, 0);
    chk("t5_wr_count", wr_count, STATS ? 7 : 0);

    // asynchronous reset while the read sits in LAT
    h2f_rdata = 32'h42; rx_ready = 1'b0; h2f_empty = 1'b0;
    f2h_waitrequest = 1'b1; wr_req1 = 1'b1; wr_data1 = 32'h33;
    tick();
    chk("t6_rd", h2f_rd, 1);
    chk("t6_wr", f2h_wr, 1);
    tick();
    chk("t6_in_lat", h2f_rd, 0);
    #4 rst = 1'b0;
    #1;
    chk("t6_rst_h2f_rd", h2f_rd, 0);
    chk("t6_rst_rx_valid", rx_valid, 0);
    chk("t6_rst_rx_data", rx_data, 0);
    chk("t6_rst_f2h_wr", f2h_wr, 0);
    chk("t6_rst_gnt0", wr_gnt0, 0);
    chk("t6_rst_gnt1", wr_gnt1, 0);
    chk("t6_rst_wr_count", wr_count, 0);
    wr_req1 = 1'b0; f2h_waitrequest = 1'b0; rx_ready = 1'b1;
    #3 rst = 1'b1;
    tick();
    chk("t6_fresh_rd", h2f_rd, 1);
    h2f_empty = 1'b1;
    tick();
    tick();
    chk("t6_fresh_valid", rx_valid, 1);
    chk("t6_fresh_data", rx_data, 32'h42);
    tick();
    chk("t6_rd_count", rd_count, STATS ? 1 : 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
